// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester, shared-multiplier and response signals of the
// mul_share_arb block, bundled as one port.
//   master : operand sources, the combinational multiplier and the response sink
//   slave  : the arbiter/sequencer itself
interface mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 12,
    parameter int PW   = 22,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [PW-1:0]     mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_p;

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one combinational multiplier among NREQ requesters.
// A winner is granted in IDLE, its operands are registered onto mul_a/mul_b,
// the product is captured after MUL_LAT cycles and returned with the winner's
// index on a valid/ready response port.
// Build option: define MUL_SHARE_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins); default is round robin starting at ptr.
//
// state | meaning
// IDLE  | waiting for a request; grant and operand latch happen here
// ISSUE | operands on the multiplier, counting down the settle time
// DONE  | product held on the response port until rsp_ready
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 12,
    parameter int PW      = 22,
    parameter int MUL_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mul_share_arb_if.slave   bus,
    output logic             o_busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_mul_a;
    logic [W-1:0]   r_mul_b;
    logic [PW-1:0]  r_rsp_p;
    logic [IDW-1:0] r_rsp_id;
`ifndef MUL_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0] r_ptr;
`endif
    logic           w_any;
    logic [IDW-1:0] w_gnt;
    logic           w_take;
    logic           w_rsp_valid;

    // Winner search: first asserted valid starting from ptr (or from 0 in fixed mode)
    always_comb begin
        int v_idx;
        v_idx = 0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_SHARE_FIXED_PRIO_EN
            v_idx = k;
`else
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
`endif
            if (!w_any && bus.req_valid[v_idx]) begin
                w_any = 1'b1;
                w_gnt = IDW'(v_idx);
            end
        end
    end

    // No grant while reset is asserted, even though the state already reads IDLE
    assign w_take = (r_state == IDLE) && w_any && !i_rst;

    // One-hot ready to the winner only
    always_comb begin
        bus.req_ready = '0;
        if (w_take) bus.req_ready[w_gnt] = 1'b1;
    end

    // Next-state and response-valid decode
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE:  if (w_take) w_state_nxt = ISSUE;
            ISSUE: if (r_cnt == '0) w_state_nxt = DONE;
            DONE: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand latch, settle counter, product capture and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_rsp_p  <= '0;
            r_rsp_id <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            r_ptr    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_mul_a  <= bus.req_a[int'(w_gnt)*W +: W];
                        r_mul_b  <= bus.req_b[int'(w_gnt)*W +: W];
                        r_rsp_id <= w_gnt;
                        r_cnt    <= CW'(MUL_LAT - 1);
`ifndef MUL_SHARE_FIXED_PRIO_EN
                        r_ptr    <= (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (r_cnt == '0) r_rsp_p <= bus.mul_p;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_valid = w_rsp_valid;
    assign o_busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: a MUL_LAT=1 instance for most scenarios and a
// MUL_LAT=3 instance for the longer settle path, each with a signed reference
// multiplier attached. Expected responses are queued at grant time and popped
// when rsp_valid appears.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 12;
    localparam int PW   = 22;
    localparam int IDW  = 2;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    logic busy1;
    logic busy3;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [IDW+PW-1:0] sb_q[$];

    mul_share_arb_if #(.NREQ(NREQ), .W(W), .PW(PW), .IDW(IDW)) bus1();
    mul_share_arb_if #(.NREQ(NREQ), .W(W), .PW(PW), .IDW(IDW)) bus3();

    mul_share_arb #(.NREQ(NREQ), .W(W), .PW(PW), .MUL_LAT(1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (bus1),
        .o_busy(busy1)
    );

    mul_share_arb #(.NREQ(NREQ), .W(W), .PW(PW), .MUL_LAT(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst3),
        .bus   (bus3),
        .o_busy(busy3)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] f;
        f = $signed(a) * $signed(b);
        return f[PW-1:0];
    endfunction

    assign bus1.mul_p = prod(bus1.mul_a, bus1.mul_b);
    assign bus3.mul_p = prod(bus3.mul_a, bus3.mul_b);

    task automatic set_op1(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus1.req_a[i*W +: W] = a;
        bus1.req_b[i*W +: W] = b;
    endtask

    task automatic do_reset1();
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    // Waits for rsp_valid on bus1, dropping req_valid once the grant edge has passed
    task automatic wait_rsp1(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            bus1.req_valid = '0;
            #1;
            if (bus1.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.req_valid = 4'b1111;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_no_grant: got %b want 0000", bus1.req_ready);
        end
        n_tests++;
        if ({busy1, bus1.rsp_valid, bus1.mul_a, bus1.mul_b, bus1.rsp_p, bus1.rsp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rv=%b a=%h b=%h p=%h id=%h want all 0",
                     busy1, bus1.rsp_valid, bus1.mul_a, bus1.mul_b, bus1.rsp_p, bus1.rsp_id);
        end
        n_tests++;
        if ({busy3, bus3.rsp_valid, bus3.mul_a, bus3.rsp_p} !== '0) begin
            n_fail++; $display("FAIL reset_state3: busy=%b rv=%b a=%h p=%h want 0",
                               busy3, bus3.rsp_valid, bus3.mul_a, bus3.rsp_p);
        end
        bus1.req_valid = '0;
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
    endtask

    task automatic test_single();
        logic [IDW+PW-1:0] e;
        @(negedge clk);
        set_op1(2, 12'd25, 12'd40);
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 4'b0100;
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant: got %b want 0100", bus1.req_ready);
        end
        sb_q.push_back({2'd2, 22'd1000});
        @(negedge clk);
        bus1.req_valid = '0;
        #1;
        n_tests++;
        if ({bus1.mul_a, bus1.mul_b, busy1, bus1.rsp_valid} !== {12'd25, 12'd40, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_issue: a=%0d b=%0d busy=%b rv=%b want 25 40 1 0",
                               bus1.mul_a, bus1.mul_b, busy1, bus1.rsp_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus1.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_rsp_valid: got %b want 1", bus1.rsp_valid);
        end
        e = sb_q.pop_front();
        n_tests++;
        if ({bus1.rsp_id, bus1.rsp_p} !== e) begin
            n_fail++; $display("FAIL single_rsp: got id=%0d p=%0d want id=%0d p=%0d",
                               bus1.rsp_id, bus1.rsp_p, e[PW+:IDW], e[PW-1:0]);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy1 !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: busy=%b want 0", busy1);
        end
    endtask

    task automatic test_round_robin();
        int order[5];
        int k;
        int last;
        logic [IDW+PW-1:0] e;
        logic [W-1:0] oa[4];
        logic [W-1:0] ob[4];
`ifdef MUL_SHARE_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        sb_q.delete();
        do_reset1();
        for (int i = 0; i < 4; i++) begin
            oa[i] = 12'(i * 37 + 5);
            ob[i] = 12'(-(i * 11 + 3));
            set_op1(i, oa[i], ob[i]);
        end
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 4'b1111;
        k = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && (k < 5 || sb_q.size() != 0); cyc++) begin
            #1;
            if (bus1.req_ready !== 4'b0000) begin
                n_tests++;
                if (k >= 5) begin
                    n_fail++; $display("FAIL rr_extra_grant: got %b want none", bus1.req_ready);
                end else begin
                    if (bus1.req_ready !== 4'(1 << order[k])) begin
                        n_fail++; $display("FAIL rr_grant[%0d]: got %b want index %0d",
                                           k, bus1.req_ready, order[k]);
                    end
                    if (k > 0) begin
                        n_tests++;
                        if (cyc - last != 3) begin
                            n_fail++; $display("FAIL rr_interval[%0d]: got %0d want 3", k, cyc - last);
                        end
                    end
                    last = cyc;
                    sb_q.push_back({2'(order[k]), prod(oa[order[k]], ob[order[k]])});
                    k++;
                end
            end
            if (bus1.rsp_valid === 1'b1) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_unexpected_rsp: id=%0d want no response", bus1.rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus1.rsp_id, bus1.rsp_p} !== e) begin
                        n_fail++; $display("FAIL rr_rsp: got id=%0d p=%h want id=%0d p=%h",
                                           bus1.rsp_id, bus1.rsp_p, e[PW+:IDW], e[PW-1:0]);
                    end
                end
            end
            @(negedge clk);
            if (k >= 5) bus1.req_valid = '0;
        end
        n_tests++;
        if (k != 5 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL rr_timeout: grants=%0d pending=%0d want 5 0", k, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [IDW+PW-1:0] e;
        bit ok;
        sb_q.delete();
        @(negedge clk);
        set_op1(1, 12'hFFB, 12'd100);
        set_op1(0, 12'd300, 12'd2);
        bus1.rsp_ready = 1'b0;
        bus1.req_valid = 4'b0010;
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant: got %b want 0010", bus1.req_ready);
        end
        e = {2'd1, prod(12'hFFB, 12'd100)};
        wait_rsp1(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_rsp_timeout: rsp_valid=%b want 1", bus1.rsp_valid);
        end
        n_tests++;
        if ({bus1.rsp_id, bus1.rsp_p} !== e) begin
            n_fail++; $display("FAIL bp_rsp: got id=%0d p=%h want id=%0d p=%h",
                               bus1.rsp_id, bus1.rsp_p, e[PW+:IDW], e[PW-1:0]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus1.req_valid = 4'b0001;
            #1;
            n_tests++;
            if ({bus1.rsp_valid, busy1, bus1.req_ready, bus1.rsp_id, bus1.rsp_p} !== {1'b1, 1'b1, 4'b0000, e}) begin
                n_fail++; $display("FAIL bp_stall[%0d]: rv=%b busy=%b rdy=%b id=%0d p=%h want 1 1 0000 %0d %h",
                                   c, bus1.rsp_valid, busy1, bus1.req_ready, bus1.rsp_id, bus1.rsp_p,
                                   e[PW+:IDW], e[PW-1:0]);
            end
        end
        @(negedge clk);
        bus1.rsp_ready = 1'b1;
        #1;
        n_tests++;
        if ({bus1.rsp_valid, bus1.req_ready} !== {1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL bp_release: rv=%b rdy=%b want 1 0000", bus1.rsp_valid, bus1.req_ready);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({busy1, bus1.rsp_valid, bus1.req_ready} !== {1'b0, 1'b0, 4'b0001}) begin
            n_fail++; $display("FAIL bp_idle: busy=%b rv=%b rdy=%b want 0 0 0001",
                               busy1, bus1.rsp_valid, bus1.req_ready);
        end
        e = {2'd0, 22'd600};
        wait_rsp1(ok);
        n_tests++;
        if (!ok || {bus1.rsp_id, bus1.rsp_p} !== e) begin
            n_fail++; $display("FAIL bp_next_rsp: ok=%b id=%0d p=%0d want 1 0 600",
                               ok, bus1.rsp_id, bus1.rsp_p);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        set_op1(1, 12'd11, 12'd13);
        set_op1(3, 12'hF9C, 12'hFFD);
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 4'b0010;
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rm_grant: got %b want 0010", bus1.req_ready);
        end
        @(negedge clk);
        bus1.req_valid = 4'b1010;
        rst1 = 1'b1;
        #1;
        n_tests++;
        if ({busy1, bus1.req_ready} !== {1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL rm_in_issue: busy=%b rdy=%b want 1 0000", busy1, bus1.req_ready);
        end
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        n_tests++;
        if ({busy1, bus1.rsp_valid, bus1.mul_a, bus1.mul_b, bus1.rsp_p, bus1.rsp_id} !== '0) begin
            n_fail++; $display("FAIL rm_cleared: busy=%b rv=%b a=%h b=%h p=%h id=%h want all 0",
                               busy1, bus1.rsp_valid, bus1.mul_a, bus1.mul_b, bus1.rsp_p, bus1.rsp_id);
        end
        n_tests++;
        if (bus1.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rm_regrant: got %b want 0010", bus1.req_ready);
        end
        wait_rsp1(ok);
        n_tests++;
        if (!ok || {bus1.rsp_id, bus1.rsp_p} !== {2'd1, 22'd143}) begin
            n_fail++; $display("FAIL rm_rsp: ok=%b id=%0d p=%0d want 1 1 143", ok, bus1.rsp_id, bus1.rsp_p);
        end
    endtask

    task automatic test_mul_lat3();
        logic [IDW+PW-1:0] e;
        sb_q.delete();
        @(negedge clk);
        bus3.req_a = '0;
        bus3.req_b = '0;
        bus3.req_a[0 +: W] = 12'hFF9;
        bus3.req_b[0 +: W] = 12'd9;
        bus3.rsp_ready = 1'b1;
        bus3.req_valid = 4'b0001;
        #1;
        n_tests++;
        if (bus3.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL l3_grant: got %b want 0001", bus3.req_ready);
        end
        sb_q.push_back({2'd0, 22'h3FFFC1});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus3.req_valid = '0;
            #1;
            n_tests++;
            if ({bus3.rsp_valid, busy3} !== 2'b01) begin
                n_fail++; $display("FAIL l3_issue[%0d]: rv=%b busy=%b want 0 1", c, bus3.rsp_valid, busy3);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus3.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL l3_valid: got %b want 1", bus3.rsp_valid);
        end
        e = sb_q.pop_front();
        n_tests++;
        if ({bus3.rsp_id, bus3.rsp_p, bus3.mul_a, bus3.mul_b} !== {e, 12'hFF9, 12'd9}) begin
            n_fail++; $display("FAIL l3_rsp: id=%0d p=%h a=%h b=%h want 0 3fffc1 ff9 009",
                               bus3.rsp_id, bus3.rsp_p, bus3.mul_a, bus3.mul_b);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy3 !== 1'b0) begin
            n_fail++; $display("FAIL l3_idle: busy=%b want 0", busy3);
        end
    endtask

    task automatic test_prio_mask();
        int order[4];
        int k;
        int last;
        logic [IDW+PW-1:0] e;
        logic [W-1:0] oa[4];
        logic [W-1:0] ob[4];
`ifdef MUL_SHARE_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 3, 0};
`endif
        sb_q.delete();
        do_reset1();
        for (int i = 0; i < 4; i++) begin
            oa[i] = 12'(i * 101 - 50);
            ob[i] = 12'(i * 3 + 7);
            set_op1(i, oa[i], ob[i]);
        end
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 4'b1011;
        k = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && (k < 4 || sb_q.size() != 0); cyc++) begin
            #1;
            if (bus1.req_ready !== 4'b0000) begin
                n_tests++;
                if (k >= 4) begin
                    n_fail++; $display("FAIL pm_extra_grant: got %b want none", bus1.req_ready);
                end else begin
                    if (bus1.req_ready !== 4'(1 << order[k])) begin
                        n_fail++; $display("FAIL pm_grant[%0d]: got %b want index %0d",
                                           k, bus1.req_ready, order[k]);
                    end
                    if (k > 0) begin
                        n_tests++;
                        if (cyc - last != 3) begin
                            n_fail++; $display("FAIL pm_interval[%0d]: got %0d want 3", k, cyc - last);
                        end
                    end
                    last = cyc;
                    sb_q.push_back({2'(order[k]), prod(oa[order[k]], ob[order[k]])});
                    k++;
                end
            end
            if (bus1.rsp_valid === 1'b1) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL pm_unexpected_rsp: id=%0d want no response", bus1.rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus1.rsp_id, bus1.rsp_p} !== e) begin
                        n_fail++; $display("FAIL pm_rsp: got id=%0d p=%h want id=%0d p=%h",
                                           bus1.rsp_id, bus1.rsp_p, e[PW+:IDW], e[PW-1:0]);
                    end
                end
            end
            @(negedge clk);
            if (k >= 4) bus1.req_valid = '0;
        end
        n_tests++;
        if (k != 4 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL pm_timeout: grants=%0d pending=%0d want 4 0", k, sb_q.size());
        end
    endtask

    initial begin
        bus1.req_valid = '0;
        bus1.req_a     = '0;
        bus1.req_b     = '0;
        bus1.rsp_ready = 1'b0;
        bus3.req_valid = '0;
        bus3.req_a     = '0;
        bus3.req_b     = '0;
        bus3.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_mul_lat3();
        test_prio_mask();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
